// File: rtl/demod_16qam_pkg.sv
// Shared types and defaults for the 16-QAM receive demodulator.
// The level codes match the transmitter's coefficient selection.
package demod_16qam_pkg;

  localparam int unsigned SPS_DEF          = 8;
  localparam int unsigned BIT_WIDTH_DEF    = 14;
  localparam int unsigned SAMPLE_PHASE_DEF = 4;
  localparam int          THRESH_DEF       = 4096;
  localparam int          ENERGY_TH_DEF    = 2048;
  localparam int unsigned LOCK_CNT_DEF     = 4;
  localparam int unsigned UNLOCK_CNT_DEF   = 8;

  typedef enum logic [1:0] {
    LVL_P3 = 2'b00,
    LVL_P1 = 2'b01,
    LVL_M1 = 2'b10,
    LVL_M3 = 2'b11
  } lvl_e;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/demod_16qam_if.sv
// Sample/symbol bus between ADC capture, the demodulator and the bit sink.
interface demod_16qam_if #(
  parameter int unsigned BIT_WIDTH = demod_16qam_pkg::BIT_WIDTH_DEF,
  parameter int unsigned SPS       = demod_16qam_pkg::SPS_DEF
);
  localparam int unsigned CNT_W = $clog2(SPS);

  logic [BIT_WIDTH-1:0] adc;
  logic                 slip;
  logic [CNT_W-1:0]     count;
  logic [3:0]           symbol;
  logic                 symbol_valid;
  logic                 locked;

  modport master (
    output adc, slip,
    input  count, symbol, symbol_valid, locked
  );

  modport slave (
    input  adc, slip,
    output count, symbol, symbol_valid, locked
  );
endinterface

// File: rtl/demod_16qam_slicer.sv
// Four-level slicer: signed rail sample to a 2-bit level code.
// Zero and exact thresholds fall into the upper bin.
module demod_16qam_slicer
  import demod_16qam_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int          THRESH    = THRESH_DEF
) (
  input  logic signed [BIT_WIDTH-1:0] s_i,
  output lvl_e                        lvl_c_o
);

  logic signed [31:0] s_ext;

  assign s_ext = 32'(s_i);

  always_comb begin
    lvl_c_o = LVL_M3;
    if (s_ext >= THRESH)       lvl_c_o = LVL_P3;
    else if (s_ext >= 0)       lvl_c_o = LVL_P1;
    else if (s_ext >= -THRESH) lvl_c_o = LVL_M1;
  end

endmodule

// File: rtl/demod_16qam.sv
// 16-QAM receive demodulator: I/Q de-interleave, phase-selectable decimation,
// four-level slicing and a signal-presence lock FSM gating symbol_valid.
module demod_16qam
  import demod_16qam_pkg::*;
#(
  parameter int unsigned SPS          = SPS_DEF,
  parameter int unsigned BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  parameter int          THRESH       = THRESH_DEF,
  parameter int          ENERGY_TH    = ENERGY_TH_DEF,
  parameter int unsigned LOCK_CNT     = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT   = UNLOCK_CNT_DEF
) (
  input  logic          clock_sample,
  input  logic          reset,
  demod_16qam_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(SPS);
  localparam int unsigned RUN_W  = $clog2(max_u(LOCK_CNT, UNLOCK_CNT) + 1);
  localparam int unsigned DEC_PH = (SAMPLE_PHASE + 2) % SPS;

  logic [CNT_W-1:0]            count_q, count_d;
  logic signed [BIT_WIDTH-1:0] s;
  logic signed [BIT_WIDTH-1:0] i_q, q_q;
  lvl_e                        i_lvl, q_lvl;
  logic [BIT_WIDTH-1:0]        abs_i, abs_q;
  logic [BIT_WIDTH:0]          energy;
  logic                        active;
  logic                        cap_i, cap_q, decide, pair_busy;
  lock_state_e                 state_q, state_d;
  logic [RUN_W-1:0]            run_q, run_d, run_inc;
  logic [3:0]                  symbol_q;
  logic                        valid_q;

  assign s = {~bus.adc[BIT_WIDTH-1], bus.adc[BIT_WIDTH-2:0]};

  assign cap_i     = (count_q == CNT_W'(SAMPLE_PHASE));
  assign cap_q     = (count_q == CNT_W'(SAMPLE_PHASE + 1));
  assign pair_busy = cap_i || cap_q;
  assign decide    = (count_q == CNT_W'(DEC_PH));

  // A slip holds the phase counter, except inside an I/Q pair.
  assign count_d = (bus.slip && !pair_busy) ? count_q : count_q + CNT_W'(1);

  demod_16qam_slicer #(.BIT_WIDTH(BIT_WIDTH), .THRESH(THRESH)) u_slice_i (
    .s_i     (i_q),
    .lvl_c_o (i_lvl)
  );

  demod_16qam_slicer #(.BIT_WIDTH(BIT_WIDTH), .THRESH(THRESH)) u_slice_q (
    .s_i     (q_q),
    .lvl_c_o (q_lvl)
  );

  // Magnitudes as unsigned so that abs(-2^(W-1)) is exact.
  assign abs_i  = i_q[BIT_WIDTH-1] ? BIT_WIDTH'(-i_q) : BIT_WIDTH'(i_q);
  assign abs_q  = q_q[BIT_WIDTH-1] ? BIT_WIDTH'(-q_q) : BIT_WIDTH'(q_q);
  assign energy = (BIT_WIDTH+1)'(abs_i) + (BIT_WIDTH+1)'(abs_q);
  assign active = $signed(32'(energy)) > ENERGY_TH;

  assign run_inc = run_q + RUN_W'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (decide) begin
      unique case (state_q)
        HUNT: begin
          if (!active) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(LOCK_CNT)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        LOCKED: begin
          if (active) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(UNLOCK_CNT)) begin
            state_d = HUNT;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_sample) begin
    if (reset) begin
      count_q  <= '0;
      i_q      <= '0;
      q_q      <= '0;
      symbol_q <= '0;
      valid_q  <= 1'b0;
      state_q  <= HUNT;
      run_q    <= '0;
    end else begin
      count_q <= count_d;
      if (cap_i)  i_q      <= s;
      if (cap_q)  q_q      <= s;
      if (decide) symbol_q <= {q_lvl, i_lvl};
      valid_q <= decide && (state_d == LOCKED);
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.symbol       = symbol_q;
  assign bus.symbol_valid = valid_q;
  assign bus.locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_demod_16qam.sv
// Directed bench for demod_16qam: reset, lock acquisition, slicing and
// boundaries, unlock run, slip handling and mid-symbol reset.
module tb_demod_16qam;

  localparam int FILL = -6144;

  logic clock_sample;
  logic reset;
  int   errors;
  int   checks;
  int   exp_cnt;
  bit   last_dec;

  demod_16qam_if bus ();

  demod_16qam dut (
    .clock_sample (clock_sample),
    .reset        (reset),
    .bus          (bus)
  );

  initial clock_sample = 1'b0;
  always #5 clock_sample = ~clock_sample;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] to_adc(input int s);
    return 14'(s) ^ 14'h2000;
  endfunction

  // One clock: drive, step past the edge, track the expected counter.
  task automatic cyc(input logic [13:0] a, input logic slp);
    int pre;
    pre = exp_cnt;
    bus.adc  = a;
    bus.slip = slp;
    @(posedge clock_sample);
    #1;
    if (reset)                          exp_cnt = 0;
    else if (slp && pre != 4 && pre != 5) exp_cnt = pre;
    else                                exp_cnt = (pre + 1) % 8;
    last_dec = !reset && (pre == 6);
    chk("count", int'(bus.count), exp_cnt);
    if (!last_dec) chk("valid_idle", int'(bus.symbol_valid), 0);
  endtask

  // Feed one symbol aligned to the counter; returns just after its decision edge.
  task automatic send_sym(input int i, input int q, input int slip_at);
    bit          done;
    bit          slipped;
    bit          is_dec;
    bit          slp;
    int          n;
    logic [13:0] a;
    done = 0; slipped = 0; n = 0;
    while (!done && n < 16) begin
      a = (exp_cnt == 4) ? to_adc(i) : (exp_cnt == 5) ? to_adc(q) : to_adc(FILL);
      slp = !slipped && (exp_cnt == slip_at);
      if (slp) slipped = 1;
      is_dec = (exp_cnt == 6);
      cyc(a, slp);
      if (is_dec) done = 1;
      n++;
    end
    if (!done) chk("sym_timeout", 0, 1);
  endtask

  task automatic chk_dec(input string tag, input int sym, input int vld, input int lck);
    chk({tag, "_sym"},   int'(bus.symbol),       sym);
    chk({tag, "_valid"}, int'(bus.symbol_valid), vld);
    chk({tag, "_lock"},  int'(bus.locked),       lck);
  endtask

  int i_sweep [4] = '{6144, 2048, -2048, -6144};
  int i_bound [5] = '{4096, 4095, 0, -4096, -4097};
  int s_bound [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0011};

  initial begin
    errors = 0; checks = 0; exp_cnt = 0; last_dec = 0;
    bus.adc = 14'h2000; bus.slip = 1'b0;

    // 1: reset then idle mid-scale input
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cyc(14'h2000, 1'b0);
    chk_dec("reset", 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(14'h2000, 1'b0);
      chk("idle_lock", int'(bus.locked), 0);
      if (last_dec) chk("idle_valid_dec", int'(bus.symbol_valid), 0);
    end

    // 2: four active symbols acquire lock
    for (int k = 0; k < 3; k++) begin
      send_sym(6144, -6144, -1);
      chk_dec("acq", 4'b1100, 0, 0);
    end
    send_sym(6144, -6144, -1);
    chk_dec("acq4", 4'b1100, 1, 1);
    cyc(to_adc(FILL), 1'b0);
    chk("acq_after_lock", int'(bus.locked), 1);

    // 3: I sweep with Q = +2048
    for (int k = 0; k < 4; k++) begin
      send_sym(i_sweep[k], 2048, -1);
      chk_dec("sweep", 4'b0100 | k, 1, 1);
    end

    // 4: slicer boundaries on I, then one on Q
    for (int k = 0; k < 5; k++) begin
      send_sym(i_bound[k], 6144, -1);
      chk_dec("bound", s_bound[k], 1, 1);
    end
    send_sym(0, -4097, -1);
    chk_dec("bound_q", 4'b1101, 1, 1);

    // 5: unlock run restarted by one active symbol
    for (int k = 0; k < 4; k++) begin
      send_sym(0, 0, -1);
      chk_dec("quiet_a", 4'b0101, 1, 1);
    end
    send_sym(6144, 6144, -1);
    chk_dec("restart", 4'b0000, 1, 1);
    for (int k = 0; k < 7; k++) begin
      send_sym(0, 0, -1);
      chk_dec("quiet_b", 4'b0101, 1, 1);
    end
    send_sym(0, 0, -1);
    chk_dec("unlock", 4'b0101, 0, 0);

    // 6: slip at count 2 honoured, at count 4 ignored
    send_sym(6144, -2048, 2);
    chk_dec("slip2", 4'b1000, 0, 0);
    send_sym(-6144, 2048, 4);
    chk_dec("slip4", 4'b0111, 0, 0);
    send_sym(6144, 6144, -1);
    chk_dec("relock3", 4'b0000, 0, 0);
    send_sym(-6144, -6144, -1);
    chk_dec("relock4", 4'b1111, 1, 1);

    // reset asserted while count == 5
    while (exp_cnt != 5) cyc(to_adc(FILL), 1'b0);
    reset = 1'b1;
    cyc(to_adc(FILL), 1'b0);
    chk_dec("midreset", 0, 0, 0);
    reset = 1'b0;
    cyc(to_adc(FILL), 1'b0);
    chk("post_reset_lock", int'(bus.locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
